// File: rtl/sample_scheduler_if.sv
// Control/DAC handshake bundle between the playback controller and its users.
// master: register block / bench side; slave: sample_scheduler.
interface sample_scheduler_if #(
  parameter int N     = 3,
  parameter int DIV_W = 16,
  parameter int CNT_W = 16
);
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  logic             start;
  logic             stop;
  logic [DIV_W-1:0] divisor;
  logic [CNT_W-1:0] repeat_cnt;
  logic             dac_ready;
  logic             next;
  logic             dac_load;
  logic             busy;
  logic             done;
  logic             underrun;
  logic [IDX_W-1:0] sample_idx;
  logic [CNT_W-1:0] wave_cnt;

  modport master (
    output start, stop, divisor, repeat_cnt, dac_ready,
    input  next, dac_load, busy, done, underrun, sample_idx, wave_cnt
  );

  modport slave (
    input  start, stop, divisor, repeat_cnt, dac_ready,
    output next, dac_load, busy, done, underrun, sample_idx, wave_cnt
  );
endinterface

// File: rtl/sample_scheduler.sv
// Playback pacing for signal2data and the DAC driver: periodic 2-cycle 'next'
// strobes, sample index / waveform repeat tracking and sticky DAC underrun flag.
module sample_scheduler #(
  parameter int N     = 3,
  parameter int DIV_W = 16,
  parameter int CNT_W = 16
) (
  input logic              clk,
  input logic              rst,
  sample_scheduler_if.slave bus
);
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);
  localparam logic [DIV_W-1:0] P_MIN    = DIV_W'(3);

  typedef enum logic [2:0] {
    S_IDLE,
    S_STROBE,
    S_LOAD,
    S_WAIT,
    S_DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [DIV_W-1:0] period_q;
  logic [DIV_W-1:0] period_cnt;
  logic [DIV_W-1:0] cnt_inc;
  logic [CNT_W-1:0] rep_q;
  logic [CNT_W-1:0] wave_q;
  logic [CNT_W-1:0] wave_inc;
  logic [IDX_W-1:0] idx_q;
  logic             underrun_q;
  logic             stop_pend;
  logic             go;
  logic             due;
  logic             idx_wrap;
  logic             rep_hit;

  always_comb begin
    go       = bus.start && !bus.stop;
    cnt_inc  = (period_cnt >= period_q) ? period_q : period_cnt + DIV_W'(1);
    due      = (cnt_inc == period_q);
    idx_wrap = (idx_q == IDX_LAST);
    wave_inc = wave_q + CNT_W'(1);
    rep_hit  = (rep_q != '0) && (wave_inc == rep_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    bus.next     = 1'b0;
    bus.dac_load = 1'b0;
    bus.busy     = 1'b1;
    bus.done     = 1'b0;
    case (state)
      S_IDLE: begin
        bus.busy = 1'b0;
        if (go) state_nxt = S_STROBE;
      end
      S_STROBE: begin
        bus.next  = 1'b1;
        state_nxt = S_LOAD;
      end
      S_LOAD: begin
        bus.next     = 1'b1;
        bus.dac_load = 1'b1;
        if (idx_wrap && rep_hit)        state_nxt = S_DONE;
        else if (bus.stop || stop_pend) state_nxt = S_IDLE;
        else                            state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (bus.stop)                  state_nxt = S_IDLE;
        else if (due && bus.dac_ready) state_nxt = S_STROBE;
      end
      S_DONE: begin
        bus.done  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        bus.busy  = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  // A stop seen during STROBE is remembered so the strobe still completes its LOAD cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      period_q   <= '0;
      period_cnt <= '0;
      rep_q      <= '0;
      wave_q     <= '0;
      idx_q      <= '0;
      underrun_q <= 1'b0;
      stop_pend  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (go) begin
            period_q   <= (bus.divisor < P_MIN) ? P_MIN : bus.divisor;
            rep_q      <= bus.repeat_cnt;
            wave_q     <= '0;
            underrun_q <= 1'b0;
            period_cnt <= '0;
            stop_pend  <= 1'b0;
          end
        end
        S_STROBE: begin
          period_cnt <= DIV_W'(1);
          if (bus.stop) stop_pend <= 1'b1;
        end
        S_LOAD: begin
          period_cnt <= period_cnt + DIV_W'(1);
          stop_pend  <= 1'b0;
          if (idx_wrap) begin
            idx_q  <= '0;
            wave_q <= wave_inc;
          end else begin
            idx_q  <= idx_q + IDX_W'(1);
          end
        end
        S_WAIT: begin
          period_cnt <= cnt_inc;
          if (!bus.stop && due && !bus.dac_ready) underrun_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.underrun   = underrun_q;
    bus.sample_idx = idx_q;
    bus.wave_cnt   = wave_q;
  end
endmodule

// File: tb/tb_sample_scheduler.sv
// Directed bench for sample_scheduler: playback pacing, minimum period, underrun,
// stop handling, start/stop collision and asynchronous reset.
module tb_sample_scheduler;
  localparam int N     = 3;
  localparam int DIV_W = 16;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  sample_scheduler_if #(.N(N), .DIV_W(DIV_W), .CNT_W(CNT_W)) sif ();

  sample_scheduler #(.N(N), .DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    sif.start      = 1'b0;
    sif.stop       = 1'b0;
    sif.divisor    = '0;
    sif.repeat_cnt = '0;
    sif.dac_ready  = 1'b1;

    // reset state
    #12;
    chk("rst_next", sif.next, 0);
    chk("rst_load", sif.dac_load, 0);
    chk("rst_busy", sif.busy, 0);
    chk("rst_done", sif.done, 0);
    chk("rst_underrun", sif.underrun, 0);
    chk("rst_idx", sif.sample_idx, 0);
    chk("rst_wave", sif.wave_cnt, 0);
    #5 rst = 1'b1;
    tick;

    // 1: P=5, two waveform periods -> 6 strobes then done
    sif.divisor    = 16'd5;
    sif.repeat_cnt = 16'd2;
    sif.start      = 1'b1;
    tick;
    for (int c = 0; c < 30; c++) begin
      if (c == 0) sif.start = 1'b0;
      chk("t1_next", sif.next, (c <= 26) && (c % 5 < 2));
      chk("t1_load", sif.dac_load, (c <= 26) && (c % 5 == 1));
      chk("t1_done", sif.done, c == 27);
      chk("t1_busy", sif.busy, c <= 27);
      if (c == 2)  chk("t1_idx_first", sif.sample_idx, 1);
      if (c == 11) chk("t1_wave0", sif.wave_cnt, 0);
      if (c == 12) begin
        chk("t1_wave1", sif.wave_cnt, 1);
        chk("t1_idx_wrap", sif.sample_idx, 0);
      end
      if (c == 27) chk("t1_wave2", sif.wave_cnt, 2);
      tick;
    end

    // 2: divisor 0 and 1 clamp to a 3-clock period
    for (int k = 0; k < 2; k++) begin
      sif.divisor    = DIV_W'(k);
      sif.repeat_cnt = '0;
      sif.start      = 1'b1;
      tick;
      sif.start = 1'b0;
      for (int c = 0; c < 9; c++) begin
        chk("t2_next", sif.next, c % 3 < 2);
        chk("t2_load", sif.dac_load, c % 3 == 1);
        if (c == 8) sif.stop = 1'b1;
        tick;
      end
      sif.stop = 1'b0;
      chk("t2_busy_end", sif.busy, 0);
      chk("t2_next_end", sif.next, 0);
      chk("t2_wave", sif.wave_cnt, 1);
      chk("t2_idx", sif.sample_idx, 0);
      chk("t2_underrun", sif.underrun, 0);
    end

    // 3: P=4, DAC not ready for 3 cycles at the due point
    sif.divisor = 16'd4;
    sif.start   = 1'b1;
    tick;
    sif.start = 1'b0;
    for (int c = 0; c < 15; c++) begin
      chk("t3_next", sif.next, (c < 2) || (c >= 7 && c <= 13 && (c - 7) % 4 < 2));
      chk("t3_load", sif.dac_load, (c == 1) || (c >= 7 && c <= 13 && (c - 7) % 4 == 1));
      chk("t3_underrun", sif.underrun, c >= 4);
      chk("t3_busy", sif.busy, c <= 13);
      if (c == 3)  sif.dac_ready = 1'b0;
      if (c == 6)  sif.dac_ready = 1'b1;
      if (c == 13) sif.stop = 1'b1;
      if (c == 14) begin
        sif.stop = 1'b0;
        chk("t3_idx", sif.sample_idx, 0);
        chk("t3_wave", sif.wave_cnt, 1);
      end
      tick;
    end

    // 4: stop during next high, restart keeps index phase, stop in WAIT
    sif.divisor = 16'd5;
    sif.start   = 1'b1;
    tick;
    sif.start = 1'b0;
    chk("t4_underrun_clr", sif.underrun, 0);
    chk("t4_next_c0", sif.next, 1);
    sif.stop = 1'b1;
    tick;
    sif.stop = 1'b0;
    chk("t4_next_c1", sif.next, 1);
    chk("t4_load_c1", sif.dac_load, 1);
    tick;
    chk("t4_next_c2", sif.next, 0);
    chk("t4_busy_c2", sif.busy, 0);
    chk("t4_idx1", sif.sample_idx, 1);
    sif.start = 1'b1;
    tick;
    sif.start = 1'b0;
    chk("t4_restart_next", sif.next, 1);
    tick;
    tick;
    chk("t4_idx2", sif.sample_idx, 2);
    chk("t4_wait_next", sif.next, 0);
    chk("t4_wait_busy", sif.busy, 1);
    sif.stop = 1'b1;
    tick;
    sif.stop = 1'b0;
    chk("t4_stop_busy", sif.busy, 0);
    chk("t4_stop_next", sif.next, 0);
    chk("t4_stop_wave", sif.wave_cnt, 0);

    // 5: start and stop together in IDLE
    sif.start = 1'b1;
    sif.stop  = 1'b1;
    tick;
    chk("t5_busy", sif.busy, 0);
    chk("t5_next", sif.next, 0);
    tick;
    chk("t5_busy2", sif.busy, 0);
    sif.start = 1'b0;
    sif.stop  = 1'b0;
    tick;
    chk("t5_idx", sif.sample_idx, 2);

    // 6: asynchronous reset while next is high
    sif.start = 1'b1;
    tick;
    sif.start = 1'b0;
    tick;
    chk("t6_next_pre", sif.next, 1);
    #2 rst = 1'b0;
    #1;
    chk("t6_next", sif.next, 0);
    chk("t6_load", sif.dac_load, 0);
    chk("t6_busy", sif.busy, 0);
    chk("t6_idx", sif.sample_idx, 0);
    chk("t6_wave", sif.wave_cnt, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    tick;
    chk("t6_post_busy", sif.busy, 0);
    chk("t6_post_next", sif.next, 0);
    chk("t6_post_idx", sif.sample_idx, 0);
    chk("t6_post_wave", sif.wave_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
